// File: rtl/reverse_bits_pkg.sv
// Shared definitions for the reverse-bits scheduler: the FSM state encoding
// and the number of requesters sharing the datapath.
package reverse_bits_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage : reverse_bits_pkg

// File: rtl/reverse_bits.sv
// Combinational bit reversal: dout_o[k] = din_i[WIDTH-1-k].
module reverse_bits #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
    assign dout_o[gi] = din_i[WIDTH-1-gi];
  end

endmodule : reverse_bits

// File: rtl/reverse_bits_sched.sv
// Two-requester round-robin scheduler sharing one bit-reversal datapath.
// Results sit in a single registered output stage that can drain and refill
// in the same cycle, so a steady stream runs at one word per clock.
module reverse_bits_sched
  import reverse_bits_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [WIDTH-1:0]   req_word0,
  input  logic [WIDTH-1:0]   req_word1,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_word,
  output logic               rsp_id,
  output logic [CNT_W-1:0]   done_cnt
);

  state_e             state_q, state_d;
  logic               last_grant_q;
  logic [WIDTH-1:0]   rsp_word_q;
  logic               rsp_id_q;
  logic [CNT_W-1:0]   done_cnt_q;

  logic [NUM_REQ-1:0] grant;
  logic               can_accept;
  logic               xfer;
  logic               sel_id;
  logic [WIDTH-1:0]   sel_word;
  logic [WIDTH-1:0]   rev_word;
  logic               rsp_fire;

  // Round-robin grant: a lone requester wins; on contention the one that
  // was not served last wins.
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end
  end

  // The stage can take a word when empty, or when its current word leaves
  // this cycle. Ready is held low while reset is asserted, since the async
  // reset already forces the stage empty.
  assign can_accept = (state_q == ST_EMPTY) || rsp_ready;
  assign req_ready  = grant & {NUM_REQ{can_accept & rst_n}};
  assign xfer       = |(req_valid & req_ready);
  assign sel_id     = grant[1];
  assign sel_word   = sel_id ? req_word1 : req_word0;
  assign rsp_fire   = (state_q == ST_FULL) && rsp_ready;

  reverse_bits #(
    .WIDTH (WIDTH)
  ) u_reverse (
    .din_i  (sel_word),
    .dout_o (rev_word)
  );

  // Next-state: a new transfer always leaves the stage full; otherwise a
  // drained result empties it and a stalled one holds.
  always_comb begin
    state_d = state_q;
    if (xfer) begin
      state_d = ST_FULL;
    end else if (rsp_fire) begin
      state_d = ST_EMPTY;
    end
  end

  // Output stage, arbitration history and completion counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      last_grant_q <= 1'b1;
      rsp_word_q   <= '0;
      rsp_id_q     <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        rsp_word_q   <= rev_word;
        rsp_id_q     <= sel_id;
        last_grant_q <= sel_id;
      end
      if (rsp_fire) begin
        done_cnt_q <= done_cnt_q + CNT_W'(1);
      end
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_word  = rsp_word_q;
  assign rsp_id    = rsp_id_q;
  assign done_cnt  = done_cnt_q;

endmodule : reverse_bits_sched

// File: tb/tb_reverse_bits_sched.sv
// Self-checking bench for reverse_bits_sched: directed scenarios followed by
// random traffic, all checked against a transaction-level reference model.
module tb_reverse_bits_sched;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_word0 = '0;
  logic [WIDTH-1:0] req_word1 = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_word;
  logic             rsp_id;
  logic [CNT_W-1:0] done_cnt;

  reverse_bits_sched #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_word0 (req_word0),
    .req_word1 (req_word1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_word  (rsp_word),
    .rsp_id    (rsp_id),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a queue holding at most one pending result, the id of
  // the last served requester and a plain integer completion count.
  int          held_word[$];
  int          held_id[$];
  int          last_word;
  int          last_id;
  int          m_last_grant;
  int          m_done;

  function automatic int reverse_int(input int w);
    int r = 0;
    int x = w;
    for (int k = 0; k < WIDTH; k++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  // Which requester the rules say should win, or -1 for none.
  function automatic int pick(input logic [1:0] v, input int last);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    if (v == 2'b11) return (last == 0) ? 1 : 0;
    return -1;
  endfunction

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    held_word.delete();
    held_id.delete();
    last_word    = 0;
    last_id      = 0;
    m_last_grant = 1;
    m_done       = 0;
  endtask

  // Assert reset between edges, confirm the asynchronous effect, release.
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    #1;
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_done_cnt", int'(done_cnt), 0);
    check("rst_rsp_word", int'(rsp_word), 0);
    check("rst_req_ready", int'(req_ready), 0);
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 2'b00;
  endtask

  // One clock: drive, check combinational and registered outputs against
  // the model, then advance the model by what the rules say happens.
  task automatic cycle(input logic [1:0] v, input logic [WIDTH-1:0] w0,
                       input logic [WIDTH-1:0] w1, input logic rr);
    int full;
    int who;
    int exp_ready;
    req_valid = v;
    req_word0 = w0;
    req_word1 = w1;
    rsp_ready = rr;
    #1;
    full = (held_word.size() != 0) ? 1 : 0;
    who  = (full == 0 || rr) ? pick(v, m_last_grant) : -1;
    exp_ready = (who < 0) ? 0 : (1 << who);
    check("req_ready", int'(req_ready), exp_ready);
    check("rsp_valid", int'(rsp_valid), full);
    check("rsp_word", int'(rsp_word), full ? held_word[0] : last_word);
    check("rsp_id", int'(rsp_id), full ? held_id[0] : last_id);
    check("done_cnt", int'(done_cnt), m_done % (1 << CNT_W));
    if (v == 2'b11 && exp_ready != 0) begin
      // With both waiting, the same requester must never be served twice running.
      check("no_starve", int'(req_ready[m_last_grant]), 0);
    end
    if (full != 0 && rr) begin
      last_word = held_word.pop_front();
      last_id   = held_id.pop_front();
      m_done++;
    end
    if (who >= 0) begin
      held_word.push_back(reverse_int(int'(who == 0 ? w0 : w1)));
      held_id.push_back(who);
      last_word    = held_word[0];
      last_id      = who;
      m_last_grant = who;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Single request from requester 0.
    cycle(2'b01, 8'h01, 8'h00, 1'b1);
    check("single_word", int'(rsp_word), 8'h80);
    check("single_id", int'(rsp_id), 0);
    cycle(2'b00, 8'h00, 8'h00, 1'b1);

    // Contention straight after reset: 0, 1, 0.
    do_reset();
    cycle(2'b11, 8'h0F, 8'hA0, 1'b1);
    check("cont1_word", int'(rsp_word), 8'hF0);
    check("cont1_id", int'(rsp_id), 0);
    cycle(2'b11, 8'h0F, 8'hA0, 1'b1);
    check("cont2_word", int'(rsp_word), 8'h05);
    check("cont2_id", int'(rsp_id), 1);
    cycle(2'b11, 8'h0F, 8'hA0, 1'b1);
    check("cont3_word", int'(rsp_word), 8'hF0);
    check("cont3_id", int'(rsp_id), 0);
    cycle(2'b00, 8'h00, 8'h00, 1'b1);

    // Backpressure: held result stays put and nothing is accepted.
    cycle(2'b01, 8'h3C, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(2'b11, 8'h55, 8'hAA, 1'b0);
      check("bp_word", int'(rsp_word), 8'h3C);
    end
    cycle(2'b10, 8'h00, 8'h01, 1'b1);
    check("bp_refill_word", int'(rsp_word), 8'h80);

    // Reset while full, then the first contention goes to requester 0.
    cycle(2'b01, 8'h12, 8'h00, 1'b0);
    do_reset();
    cycle(2'b11, 8'h01, 8'h02, 1'b1);
    check("post_rst_id", int'(rsp_id), 0);
    cycle(2'b00, 8'h00, 8'h00, 1'b1);

    // Counter wrap with a 4-bit counter: 17 completions read as 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(2'b01, 8'($urandom), 8'h00, 1'b1);
    end
    cycle(2'b00, 8'h00, 8'h00, 1'b1);
    check("wrap_cnt", int'(done_cnt), 1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(2'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 2; i++) begin
      cycle(2'b00, 8'h00, 8'h00, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_reverse_bits_sched

// File: doc/reverse_bits_sched.md
REVERSE_BITS_SCHED -- requirements
Module: reverse_bits_sched

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data word width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the completed-transaction counter width.

Ports:
REQ-003 The block SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port req_valid  in  2  per-requester request valid (bit i = requester i).
REQ-006 The block SHALL have port req_ready  out  2  per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-007 The block SHALL have port req_word0  in  WIDTH  requester 0 data word.
REQ-008 The block SHALL have port req_word1  in  WIDTH  requester 1 data word.
REQ-009 The block SHALL have port rsp_valid  out  1  result valid.
REQ-010 The block SHALL have port rsp_ready  in  1  downstream accept.
REQ-011 The block SHALL have port rsp_word  out  WIDTH  bit-reversed result: rsp_word[k] = accepted word[WIDTH-1-k].
REQ-012 The block SHALL have port rsp_id  out  1  index of the requester that owns rsp_word.
REQ-013 The block SHALL have port done_cnt  out  CNT_W  count of completed response transfers.

Function
REQ-014 The block SHALL share one reverse datapath between the two requesters through a single-entry registered output stage.
REQ-015 The FSM SHALL have two states: EMPTY (no result held) and FULL (result held, rsp_valid=1).
REQ-016 can_accept SHALL be 1 in EMPTY, and in FULL when rsp_ready=1 (same-cycle drain and refill).
REQ-017 Arbitration SHALL be round-robin on last_grant:
- only one req_valid high -> that requester is granted;
- both high -> the requester not equal to last_grant is granted;
- none high -> no grant.
REQ-018 req_ready[i] SHALL equal grant[i] AND can_accept, combinationally; at most one bit is high per cycle.
REQ-019 On a request transfer, the next edge SHALL load rsp_word with the reversed word, load rsp_id=i, set last_grant=i, and enter FULL; latency is exactly 1 cycle.
REQ-020 In FULL with rsp_ready=0, rsp_word, rsp_id and rsp_valid SHALL hold stable and req_ready SHALL be 2'b00.
REQ-021 In FULL with rsp_ready=1 and no new transfer, the block SHALL go to EMPTY; with a new transfer it SHALL stay FULL with the new data (full throughput, one word per cycle).
REQ-022 done_cnt SHALL increment by 1 on each rsp_valid AND rsp_ready cycle and wrap from 2^CNT_W-1 to 0.
REQ-023 req_word inputs SHALL be ignored when their requester is not granted; req_valid deasserting without a transfer is legal and SHALL have no effect.
REQ-024 Outputs SHALL have no combinational path from rsp_ready to rsp_word, rsp_id or rsp_valid.

Reset
REQ-025 While rst_n=0, the block SHALL asynchronously force: state EMPTY, rsp_valid 0, rsp_word 0, rsp_id 0, last_grant 1 (so requester 0 wins the first contention), done_cnt 0; req_ready SHALL be 2'b00 during reset.
REQ-026 Reset asserted mid-transaction SHALL discard any held result without a response transfer; operation SHALL resume from the REQ-025 state at the first edge after release.

Structure
REQ-027 The state enumeration (EMPTY/FULL) and the requester-count constant (2) SHALL live in a shared package, reverse_bits_pkg.
REQ-028 The bit reversal SHALL be a single instance of the team's combinational reverse_bits unit (WIDTH-generic) fed by the arbiter mux; the arbiter, FSM and counter SHALL remain in this module.

Verification
REQ-029 Single request: req_valid=01, req_word0=0x01 -> req_ready=01 that cycle; next cycle rsp_valid=1, rsp_word=0x80, rsp_id=0.
REQ-030 Contention after reset: both valid with words 0x0F and 0xA0 and rsp_ready=1 -> responses in order 0xF0 (id 0), then 0x05 (id 1), then 0xF0 (id 0) on consecutive cycles.
REQ-031 Backpressure: rsp_ready=0 for 5 cycles while FULL with 0x3C -> rsp_word stays 0x3C, req_ready=00 throughout; when rsp_ready=1, a new request is accepted the same cycle.
REQ-032 Reset mid-operation: rst_n pulled low while FULL -> rsp_valid=0, done_cnt=0 immediately with no clock edge needed; the first post-reset contention grants requester 0.
REQ-033 Counter wrap: run with CNT_W=4 for 17 completed transfers -> done_cnt reads 1.
REQ-034 Random stimulus with a scoreboard: every accepted word appears exactly once, in acceptance order, reversed, with the correct id, and no requester is starved for more than 1 grant while the other is continuously valid.
